uart_rx_byte: RTL and testbench

- 8N1 UART receiver that deserialises the board RX pin into bytes.
- Sits directly upstream of the SoC's 8-bit load registers: data_out drives d_in and data_valid drives load.
- PicoBlaze reads the captured byte from that register through an input port.
- Mid-bit sampling against a fixed clocks-per-bit count, with a two-flop input synchroniser.

---
 rtl/uart_rx_byte_if.sv | 25 ++
 rtl/uart_rx_byte.sv | 127 ++++++++++++
 tb/tb_uart_rx_byte.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_if.sv
// Signal bundle between the 8N1 receiver and the byte load register it feeds.
// The master side is the receiver; the slave side drives rx and consumes the bytes.
interface uart_rx_byte_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    modport master (
        input  rx,
        output data_out,
        output data_valid,
        output framing_error,
        output busy
    );

    modport slave (
        output rx,
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling on a fixed
// clocks-per-bit count, one-cycle data_valid / framing_error pulses.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_byte_if.master bus
);

    if (CLKS_PER_BIT < 8) begin : g_bad_clks
        $error("uart_rx_byte: CLKS_PER_BIT must be at least 8");
    end
    if ((64'd1 << CNT_W) <= 64'(CLKS_PER_BIT)) begin : g_bad_cnt_w
        $error("uart_rx_byte: CNT_W too narrow for CLKS_PER_BIT");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            sync1_q   <= sync1_d;
            rx_s_q    <= rx_s_d;
        end
    end

    // Returning to IDLE at the stop-bit midpoint leaves half a bit to catch
    // the next start edge, so back-to-back frames are never missed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        sync1_d   = bus.rx;
        rx_s_d    = sync1_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.data_out      = data_q;
        bus.data_valid    = valid_q;
        bus.framing_error = ferr_q;
        bus.busy          = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit with a pulse scoreboard.
module tb_uart_rx_byte;

    localparam int CPB = 16;

    typedef struct {
        bit         err;
        bit         both;
        logic [7:0] data;
        int         cyc;
    } obs_t;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         fall;
    } exp_t;

    logic clk;
    logic reset;
    uart_rx_byte_if bus ();

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         failures;
    int         cyc;
    bit         busy_seen;
    logic [7:0] last_good;
    obs_t       obs_q[$];
    exp_t       exp_q[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every clock step goes through here so that no output pulse can slip by unobserved.
    task automatic tick(input int n);
        obs_t o;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.busy) busy_seen = 1'b1;
            if (bus.data_valid || bus.framing_error) begin
                o.err  = bus.framing_error;
                o.both = bus.data_valid && bus.framing_error;
                o.data = bus.data_out;
                o.cyc  = cyc;
                obs_q.push_back(o);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        exp_t e;
        e.fall = cyc;
        e.err  = !stop_bit;
        if (stop_bit) begin
            e.data    = data;
            last_good = data;
        end else begin
            e.data = last_good;
        end
        exp_q.push_back(e);
        bus.rx = 1'b0;
        tick(CPB);
        for (int b = 0; b < 8; b++) begin
            bus.rx = data[b];
            tick(CPB);
        end
        bus.rx = stop_bit;
        tick(CPB);
        bus.rx = 1'b1;
    endtask

    task automatic reconcile(input string tag);
        obs_t o;
        exp_t e;
        int   lat;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o   = obs_q.pop_front();
            e   = exp_q.pop_front();
            lat = o.cyc - e.fall;
            check({tag, "_kind"}, 32'(o.err), 32'(e.err));
            check({tag, "_excl"}, 32'(o.both), 0);
            check({tag, "_data"}, 32'(o.data), 32'(e.data));
            check({tag, "_lat"}, 32'(lat >= 154 && lat <= 156), 1);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        busy_seen = 1'b0;
        last_good = 8'h00;
        bus.rx    = 1'b1;
        reset     = 1'b0;

        tick(3);
        check("rst_data", 32'(bus.data_out), 0);
        check("rst_valid", 32'(bus.data_valid), 0);
        check("rst_ferr", 32'(bus.framing_error), 0);
        check("rst_busy", 32'(bus.busy), 0);

        reset = 1'b1;
        busy_seen = 1'b0;
        tick(100);
        check("idle_busy", 32'(busy_seen), 0);
        check("idle_data", 32'(bus.data_out), 0);
        reconcile("idle");

        send_frame(8'hA5, 1'b1);
        tick(5);
        reconcile("a5");
        check("a5_hold", 32'(bus.data_out), 32'hA5);

        busy_seen = 1'b0;
        bus.rx = 1'b0;
        tick(4);
        bus.rx = 1'b1;
        tick(20);
        check("glitch_busy_rose", 32'(busy_seen), 1);
        check("glitch_busy_fell", 32'(bus.busy), 0);
        reconcile("glitch");
        check("glitch_data", 32'(bus.data_out), 32'hA5);

        send_frame(8'h3C, 1'b0);
        tick(5);
        reconcile("ferr");
        check("ferr_hold", 32'(bus.data_out), 32'hA5);
        tick(CPB * 2);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(5);
        check("b2b_pulses", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("b2b_gap", 32'(obs_q[1].cyc - obs_q[0].cyc), 160);
        end
        reconcile("b2b");
        check("b2b_final", 32'(bus.data_out), 32'hFF);

        // Abort a frame of 8'h77 halfway through data bit 4.
        bus.rx = 1'b0;
        tick(CPB);
        for (int b = 0; b < 4; b++) begin
            bus.rx = (b == 3) ? 1'b0 : 1'b1;
            tick(CPB);
        end
        bus.rx = 1'b1;
        tick(CPB / 2);
        check("abort_busy_before", 32'(bus.busy), 1);
        reset = 1'b0;
        #1;
        check("abort_busy_async", 32'(bus.busy), 0);
        check("abort_data_async", 32'(bus.data_out), 0);
        last_good = 8'h00;
        tick(3);
        reset = 1'b1;
        tick(200);
        reconcile("abort");
        check("abort_data", 32'(bus.data_out), 0);

        send_frame(8'h5A, 1'b1);
        tick(5);
        reconcile("5a");
        check("5a_hold", 32'(bus.data_out), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
